span_scheduler: RTL and testbench



---
 rtl/span_scheduler.sv | 136 +++++++++++++
 tb/tb_span_scheduler.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/span_scheduler.sv
// Span command FIFO and req_2/ack_2 issue sequencer feeding the z-buffered span fill engine.
// The current span's endpoints and colour are held in output registers for the whole fill.
module span_scheduler #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [23:0]      in_a,
    input  logic [23:0]      in_b,
    input  logic [23:0]      in_rgb,
    output logic             req_2,
    input  logic             ack_2,
    output logic [23:0]      point_out_a,
    output logic [23:0]      point_out_b,
    output logic [23:0]      rgb,
    output logic [CNT_W-1:0] count,
    output logic             span_done,
    output logic             idle
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, RUN} state_t;

    state_t           state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [71:0]      mem_q [DEPTH];
    logic [71:0]      mem_d [DEPTH];
    logic             req_q, req_d;
    logic             done_q, done_d;
    logic [23:0]      pa_q, pa_d;
    logic [23:0]      pb_q, pb_d;
    logic [23:0]      rgb_q, rgb_d;
    logic             push, pop;

    // Full check deliberately ignores a same-cycle pop to keep in_ready off the FSM path.
    assign in_ready = rst && (count_q != CNT_W'(DEPTH));
    assign push     = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        done_d  = 1'b0;
        pa_d    = pa_q;
        pb_d    = pb_q;
        rgb_d   = rgb_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                // A stale ack_2 from an engine still coming out of reset blocks the load.
                if (count_q != '0 && !ack_2) begin
                    pa_d    = mem_q[rd_ptr_q][71:48];
                    pb_d    = mem_q[rd_ptr_q][47:24];
                    rgb_d   = mem_q[rd_ptr_q][23:0];
                    pop     = 1'b1;
                    req_d   = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                // Dropping req_2 on the first ack keeps the engine from re-firing the span.
                if (ack_2) begin
                    req_d   = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!ack_2) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = {in_a, in_b, in_rgb};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            req_q    <= 1'b0;
            done_q   <= 1'b0;
            pa_q     <= '0;
            pb_q     <= '0;
            rgb_q    <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            req_q    <= req_d;
            done_q   <= done_d;
            pa_q     <= pa_d;
            pb_q     <= pb_d;
            rgb_q    <= rgb_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign req_2       = req_q;
    assign span_done   = done_q;
    assign point_out_a = pa_q;
    assign point_out_b = pb_q;
    assign rgb         = rgb_q;
    assign count       = count_q;
    assign idle        = (count_q == '0) && (state_q == IDLE) && !ack_2;

endmodule

// File: tb/tb_span_scheduler.sv
// Bench for span_scheduler: scoreboard of pushed spans, fill-engine model, directed and random traffic.
module tb_span_scheduler;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [23:0] in_a = '0, in_b = '0, in_rgb = '0;
    logic        req_2;
    logic        ack_2;
    logic [23:0] point_out_a, point_out_b, rgb;
    logic [3:0]  count;
    logic        span_done;
    logic        idle;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    int rise_cnt = 0;
    logic [71:0] sb [$];

    logic eng_en   = 1'b0;
    logic eng_rand = 1'b0;
    int   eng_hold = 12;

    span_scheduler #(.DEPTH(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_rgb(in_rgb),
        .req_2(req_2), .ack_2(ack_2),
        .point_out_a(point_out_a), .point_out_b(point_out_b), .rgb(rgb),
        .count(count), .span_done(span_done), .idle(idle)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Call at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic push(input logic [23:0] a, input logic [23:0] b, input logic [23:0] c);
        int t = 0;
        in_a = a; in_b = b; in_rgb = c; in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back({a, b, c});
                break;
            end
            t++;
            if (t > 500) begin
                tests++; fails++;
                $display("FAIL push_timeout: in_ready stayed %0b, required 1", in_ready);
                break;
            end
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(idle && sb.size() == 0) && t < 2000);
        tests++;
        if (!(idle && sb.size() == 0)) begin
            fails++;
            $display("FAIL %s_drain: idle=%0b pending=%0d, required idle=1 pending=0", name, idle, sb.size());
        end
    endtask

    function automatic logic [23:0] r24();
        return 24'($urandom);
    endfunction

    // Fill engine: samples req_2, raises ack_2 the next cycle, holds it, aborts on reset.
    initial begin
        int hold;
        ack_2 = 1'b0;
        forever begin
            @(negedge clk);
            if (rst && eng_en && req_2 && !ack_2) begin
                @(posedge clk);
                #1 ack_2 = 1'b1;
                hold = eng_rand ? int'($urandom_range(1, 6)) : eng_hold;
                for (int k = 0; k < hold; k++) begin
                    @(posedge clk);
                    if (!rst) break;
                end
                #1 ack_2 = 1'b0;
            end
        end
    end

    // Monitor: issue order, hold stability, no re-fire, span_done bookkeeping.
    initial begin
        logic        prev_req = 1'b0;
        logic        prev_ack = 1'b0;
        logic        busy = 1'b0;
        logic [71:0] held = '0;
        logic [71:0] exp;
        forever begin
            @(negedge clk);
            if (!rst) begin
                busy = 1'b0;
            end else begin
                if (req_2 && !prev_req) begin
                    rise_cnt++;
                    tests++;
                    if (sb.size() == 0) begin
                        fails++;
                        $display("FAIL issue_unexpected: span %0h issued, required none pending",
                                 {point_out_a, point_out_b, rgb});
                    end else begin
                        exp = sb.pop_front();
                        if ({point_out_a, point_out_b, rgb} !== exp) begin
                            fails++;
                            $display("FAIL issue_order: got %0h, required %0h",
                                     {point_out_a, point_out_b, rgb}, exp);
                        end
                    end
                    held = {point_out_a, point_out_b, rgb};
                    busy = 1'b1;
                end else if (busy) begin
                    tests++;
                    if ({point_out_a, point_out_b, rgb} !== held) begin
                        fails++;
                        $display("FAIL hold_stable: got %0h, required %0h",
                                 {point_out_a, point_out_b, rgb}, held);
                    end
                end
                if (ack_2 && prev_ack) begin
                    tests++;
                    if (req_2) begin
                        fails++;
                        $display("FAIL no_refire: req_2=%0b while ack_2 held, required 0", req_2);
                    end
                end
                if (span_done) begin
                    done_cnt++;
                    tests++;
                    if (!busy) begin
                        fails++;
                        $display("FAIL span_done_unexpected: span_done=1, required 0");
                    end
                    busy = 1'b0;
                end
            end
            prev_req = req_2;
            prev_ack = ack_2;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, r0;
        logic [23:0] fa [10];
        logic [23:0] fb [10];
        logic [23:0] fc [10];

        // Reset then idle
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("in_ready_in_reset", 96'(in_ready), 96'(0));
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("reset_req", 96'(req_2), 96'(0));
        chk("reset_count", 96'(count), 96'(0));
        chk("reset_idle", 96'(idle), 96'(1));
        chk("reset_in_ready", 96'(in_ready), 96'(1));
        chk("reset_outputs", 96'({point_out_a, point_out_b, rgb, span_done}), 96'(0));
        step();

        // Single span, engine holds ack for 12 cycles
        eng_en = 1'b1; eng_rand = 1'b0; eng_hold = 12;
        d0 = done_cnt; r0 = rise_cnt;
        push(24'h102005, 24'h402030, 24'hFF8040);
        @(negedge clk);
        chk("single_req_n1", 96'(req_2), 96'(0));
        chk("single_count_n1", 96'(count), 96'(1));
        @(negedge clk);
        chk("single_req_n2", 96'(req_2), 96'(1));
        chk("single_data", 96'({point_out_a, point_out_b, rgb}), 96'({24'h102005, 24'h402030, 24'hFF8040}));
        wait_idle("single");
        chk("single_done_once", 96'(done_cnt - d0), 96'(1));
        chk("single_idle_after", 96'(idle), 96'(1));
        step();

        // Fill FIFO with the engine stalled; includes zero-length and reversed spans
        eng_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            fa[i] = r24(); fb[i] = r24(); fc[i] = r24();
        end
        fb[2] = fa[2];
        fa[3] = {8'hF0, fa[3][15:0]}; fb[3] = {8'h05, fa[3][15:0]};
        for (int i = 0; i < 9; i++) push(fa[i], fb[i], fc[i]);
        @(negedge clk);
        chk("full_count", 96'(count), 96'(8));
        chk("full_in_ready", 96'(in_ready), 96'(0));
        fork
            push(fa[9], fb[9], fc[9]);
            begin
                repeat (4) @(negedge clk);
                chk("full_held_count", 96'(count), 96'(8));
                chk("full_held_valid", 96'({in_valid, in_ready}), 96'(2'b10));
                eng_en = 1'b1; eng_rand = 1'b1;
            end
        join
        wait_idle("fill");
        step();

        // Simultaneous push and pop at count=1
        eng_en = 1'b0;
        push(r24(), r24(), r24());
        push(r24(), r24(), r24());
        @(negedge clk);
        chk("pushpop_count", 96'(count), 96'(1));
        chk("pushpop_req", 96'(req_2), 96'(1));
        eng_en = 1'b1;
        wait_idle("pushpop");
        step();

        // Long ack: no re-fire, exactly one span_done
        eng_rand = 1'b0; eng_hold = 50;
        d0 = done_cnt; r0 = rise_cnt;
        push(r24(), r24(), r24());
        wait_idle("long_ack");
        chk("long_ack_done", 96'(done_cnt - d0), 96'(1));
        chk("long_ack_issues", 96'(rise_cnt - r0), 96'(1));
        step();

        // Reset in RUN with 3 spans queued
        eng_hold = 20;
        for (int i = 0; i < 4; i++) push(r24(), r24(), r24());
        @(negedge clk);
        chk("midrun_count", 96'(count), 96'(3));
        chk("midrun_state", 96'({ack_2, req_2}), 96'(2'b10));
        d0 = done_cnt;
        step();
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("midrun_in_ready_rst", 96'(in_ready), 96'(0));
        @(negedge clk);
        chk("midrun_count_rst", 96'(count), 96'(0));
        chk("midrun_req_rst", 96'(req_2), 96'(0));
        chk("midrun_outputs_rst", 96'({point_out_a, point_out_b, rgb}), 96'(0));
        chk("midrun_done_rst", 96'(span_done), 96'(0));
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("midrun_idle_after", 96'(idle), 96'(1));
        chk("midrun_no_done", 96'(done_cnt - d0), 96'(0));
        step();

        // Random traffic with random engine hold times
        eng_rand = 1'b1;
        d0 = done_cnt;
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) step();
            push(r24(), r24(), r24());
        end
        wait_idle("random");
        chk("random_done_count", 96'(done_cnt - d0), 96'(40));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
